writeback_merge: RTL and testbench

WRITEBACK_MERGE -- requirements
Module: writeback_merge

---
 rtl/writeback_merge.sv | 70 +++++++
 tb/tb_writeback_merge.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/writeback_merge.sv
// writeback_merge: merges unstallable ALU results with buffered load results into one register-file write port.
// Define WRITEBACK_MERGE_SCOREBOARD_EN to compile in per-register pending-load tracking on busy.
module writeback_merge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic [4:0]  a3,
  output logic [31:0] write_data,
  output logic        write_enable
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [4:0]  rd_mem   [FIFO_DEPTH];
  logic [31:0] data_mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic push, pop;
  logic [4:0] head_rd;
  assign ld_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && count != '0;
  assign head_rd  = rd_mem[head];
  always_ff @(posedge clk)
    if (push && !reset) begin
      rd_mem[tail]   <= ld_rd;
      data_mem[tail] <= ld_data;
    end
  always_ff @(posedge clk)
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      a3           <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else begin
      head         <= head + AW'(pop);
      tail         <= tail + AW'(push);
      count        <= count + (AW+1)'(push) - (AW+1)'(pop);
      write_enable <= alu_valid ? alu_rd != '0 : pop && head_rd != '0;
      if (alu_valid) begin
        a3         <= alu_rd;
        write_data <= alu_data;
      end else if (pop) begin
        a3         <= head_rd;
        write_data <= data_mem[head];
      end
    end
`ifdef WRITEBACK_MERGE_SCOREBOARD_EN
  // set is OR-ed after the clear so a same-cycle issue keeps the bit pending
  always_ff @(posedge clk)
    if (reset) busy <= '0;
    else busy <= ((busy & ~(pop ? 32'(1) << head_rd : '0))
                 | (issue_valid ? 32'(1) << issue_rd : '0)) & ~32'h1;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy = '0;
`endif
endmodule

// File: tb/tb_writeback_merge.sv
// tb_writeback_merge: directed checks of writeback_merge ordering, backpressure, x0 suppression, scoreboard and reset.
module tb_writeback_merge;
  logic clk = 1'b0, reset = 1'b1;
  logic alu_valid = 0, ld_valid = 0, issue_valid = 0;
  logic [4:0] alu_rd = 0, ld_rd = 0, issue_rd = 0;
  logic [31:0] alu_data = 0, ld_data = 0;
  logic ld_ready, write_enable;
  logic [31:0] busy, write_data;
  logic [4:0] a3;
  int n_vec = 0, n_err = 0;

  writeback_merge #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .a3(a3), .write_data(write_data), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 32'(write_enable), 32'(we));
    chk({tag, "_a3"}, 32'(a3), 32'(rd));
    chk({tag, "_wd"}, write_data, d);
  endtask

  initial begin
    tick();
    tick();
    chk_wr("reset", 0, 0, 0);
    chk("reset_busy", busy, 0);
    reset = 0;
    tick();
    chk("ready_after_reset", 32'(ld_ready), 1);

    // single ALU write, then hold with no write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk_wr("alu", 1, 5, 32'hDEADBEEF);
    tick();
    chk_wr("idle_hold", 0, 5, 32'hDEADBEEF);

    // load latency: no bypass, written two cycles after acceptance
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    chk("ld_ready_empty", 32'(ld_ready), 1);
    tick();
    ld_valid = 0;
    chk("ld_n1_we", 32'(write_enable), 0);
    tick();
    chk_wr("ld_n2", 1, 7, 32'h1234);
    tick();
    chk("ld_done_we", 32'(write_enable), 0);

    // ALU starves the FIFO while five loads are offered
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1; alu_rd = 5'(k + 1); alu_data = 32'(100 + k);
      ld_valid = 1; ld_rd = 5'(11 + (k < 4 ? k : 4)); ld_data = 32'hA0 + 32'(k < 4 ? k : 4);
      chk($sformatf("starve_ready%0d", k), 32'(ld_ready), k < 4 ? 1 : 0);
      tick();
      chk_wr($sformatf("starve_alu%0d", k), 1, 5'(k + 1), 32'(100 + k));
    end
    alu_valid = 0;
    chk("full_ready", 32'(ld_ready), 0);
    tick();
    chk_wr("drain0", 1, 11, 32'hA0);
    chk("after_pop_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 0;
    chk_wr("drain1", 1, 12, 32'hA1);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk_wr($sformatf("drain%0d", k), 1, 5'(11 + k), 32'hA0 + 32'(k));
    end
    tick();
    chk("drained_we", 32'(write_enable), 0);

    // x0 writes suppressed, FIFO entry still consumed
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
    tick();
    alu_valid = 0; ld_valid = 0;
    chk_wr("alu_x0", 0, 0, 32'h55);
    tick();
    chk_wr("ld_x0", 0, 0, 32'h66);
    tick();
    chk("x0_idle_we", 32'(write_enable), 0);

    // scoreboard set/clear collision and x0
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
`ifdef WRITEBACK_MERGE_SCOREBOARD_EN
    chk("busy_set9", busy, 32'h200);
`else
    chk("busy_off", busy, 0);
`endif
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    tick();
    ld_valid = 0;
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    chk_wr("ld_x9", 1, 9, 32'h99);
`ifdef WRITEBACK_MERGE_SCOREBOARD_EN
    chk("busy_set_wins", busy, 32'h200);
`else
    chk("busy_off2", busy, 0);
`endif
    issue_valid = 1; issue_rd = 0;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h98;
    tick();
    issue_valid = 0; ld_valid = 0;
`ifdef WRITEBACK_MERGE_SCOREBOARD_EN
    chk("busy_x0", busy, 32'h200);
`else
    chk("busy_off3", busy, 0);
`endif
    tick();
    chk_wr("ld_x9b", 1, 9, 32'h98);
    chk("busy_cleared", busy, 0);

    // reset mid-operation with three buffered loads and pending bits
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h70; issue_valid = 1; issue_rd = 7;
    tick();
    ld_rd = 9; ld_data = 32'h90; issue_rd = 9;
    tick();
    ld_rd = 20; ld_data = 32'h200; issue_valid = 0;
    tick();
`ifdef WRITEBACK_MERGE_SCOREBOARD_EN
    chk("busy_pre_reset", busy, 32'h280);
`else
    chk("busy_pre_reset_off", busy, 0);
`endif
    reset = 1; issue_valid = 1; issue_rd = 3; ld_rd = 4;
    tick();
    chk_wr("mid_reset", 0, 0, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_ready", 32'(ld_ready), 1);
    reset = 0; alu_valid = 0; ld_valid = 0; issue_valid = 0;
    tick();
    chk("post_reset_we", 32'(write_enable), 0);
    chk("post_reset_ready", 32'(ld_ready), 1);
    tick();
    chk("post_reset_we2", 32'(write_enable), 0);
    chk("post_reset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
